// File: rtl/cpu_loader.sv
// cpu_loader: streams a program image and a data image into the CPU memories, then runs the CPU for C cycles.
// Latency: an accepted word drives its memory write on the next cycle; cpu_enable rises the cycle after C is accepted.
// Backpressure: s_ready is high in header/load states unless a write/readback is in flight; s_valid low stalls in place.
//
// Optional feature macro: CPU_LOADER_READBACK_EN (each write is read back and compared; mismatch -> ERR code 3).
//
// Ports:
//   clk, arst_n                         clock, asynchronous active-low reset
//   start                               begins a load from IDLE/DONE/ERR
//   s_valid, s_data, s_ready            input word stream (N, N words, M, M words, C)
//   addr/wdata/wen/ren/rdata_ext        instruction memory port
//   addr/wdata/wen/ren/rdata_ext_2      data memory port
//   cpu_enable                          CPU run enable
//   busy, done, error, err_code         status (err_code: 1 imem overflow, 2 dmem overflow, 3 readback mismatch)

module cpu_loader #(
   parameter int unsigned IMEM_DEPTH = 512,
   parameter int unsigned DMEM_DEPTH = 1024,
   parameter int unsigned ADDR_STEP  = 4
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic [31:0] addr_ext,
   output logic [31:0] wdata_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   input  logic [31:0] rdata_ext,
   output logic [31:0] addr_ext_2,
   output logic [31:0] wdata_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   input  logic [31:0] rdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code
);

`ifdef CPU_LOADER_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   localparam logic [31:0] IMEM_LIM = 32'(IMEM_DEPTH);
   localparam logic [31:0] DMEM_LIM = 32'(DMEM_DEPTH);
   localparam logic [31:0] STEP     = 32'(ADDR_STEP);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR_I, S_LOAD_I, S_HDR_D, S_LOAD_D, S_HDR_C, S_RUN, S_DONE, S_ERR
   } state_t;

   // Readback phase: the write cycle, then the read cycle whose data is compared at its closing edge.
   typedef enum logic [1:0] {RB_NONE, RB_WR, RB_RD} rb_t;

   state_t      r_state;
   state_t      w_state_nxt;
   rb_t         r_rb;
   logic [31:0] r_cnt;
   logic [31:0] r_idx;
   logic [31:0] r_run_cnt;
   logic [1:0]  r_err_code;
   logic [31:0] r_addr_ext,  r_wdata_ext;
   logic [31:0] r_addr_ext_2, r_wdata_ext_2;
   logic        r_wen_ext, r_ren_ext, r_wen_ext_2, r_ren_ext_2;
   logic        r_cpu_enable;

   logic        w_accept;
   logic        w_last;
   logic        w_rb_cmp;
   logic        w_rb_mis;
   logic        w_clear, w_hdr_ld, w_wr_i, w_wr_d, w_run_ld, w_err_set;
   logic [1:0]  w_err_val;

   assign s_ready = ((r_state == S_HDR_I) || (r_state == S_LOAD_I) || (r_state == S_HDR_D) ||
                     (r_state == S_LOAD_D) || (r_state == S_HDR_C)) && (r_rb == RB_NONE);
   assign w_accept = s_valid & s_ready;
   assign w_last   = (r_idx == (r_cnt - 32'd1));
   assign w_rb_cmp = (r_rb == RB_RD);
   assign w_rb_mis = (r_state == S_LOAD_I) ? (rdata_ext   != r_wdata_ext)
                                           : (rdata_ext_2 != r_wdata_ext_2);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next state and datapath strobes ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_hdr_ld    = 1'b0;
      w_wr_i      = 1'b0;
      w_wr_d      = 1'b0;
      w_run_ld    = 1'b0;
      w_err_set   = 1'b0;
      w_err_val   = 2'd0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               w_state_nxt = S_HDR_I;
               w_clear     = 1'b1;
            end
         end
         S_HDR_I: begin
            if (w_accept) begin
               if (s_data > IMEM_LIM) begin
                  w_state_nxt = S_ERR;
                  w_err_set   = 1'b1;
                  w_err_val   = 2'd1;
               end else if (s_data == 32'd0) begin
                  w_state_nxt = S_HDR_D;
               end else begin
                  w_state_nxt = S_LOAD_I;
                  w_hdr_ld    = 1'b1;
               end
            end
         end
         S_LOAD_I: begin
            if (w_accept) begin
               w_wr_i = 1'b1;
               if (!RB_EN && w_last) w_state_nxt = S_HDR_D;
            end
            // With readback the state is held until the last word has been verified.
            if (w_rb_cmp) begin
               if (w_rb_mis) begin
                  w_state_nxt = S_ERR;
                  w_err_set   = 1'b1;
                  w_err_val   = 2'd3;
               end else if (r_idx == r_cnt) begin
                  w_state_nxt = S_HDR_D;
               end
            end
         end
         S_HDR_D: begin
            if (w_accept) begin
               if (s_data > DMEM_LIM) begin
                  w_state_nxt = S_ERR;
                  w_err_set   = 1'b1;
                  w_err_val   = 2'd2;
               end else if (s_data == 32'd0) begin
                  w_state_nxt = S_HDR_C;
               end else begin
                  w_state_nxt = S_LOAD_D;
                  w_hdr_ld    = 1'b1;
               end
            end
         end
         S_LOAD_D: begin
            if (w_accept) begin
               w_wr_d = 1'b1;
               if (!RB_EN && w_last) w_state_nxt = S_HDR_C;
            end
            if (w_rb_cmp) begin
               if (w_rb_mis) begin
                  w_state_nxt = S_ERR;
                  w_err_set   = 1'b1;
                  w_err_val   = 2'd3;
               end else if (r_idx == r_cnt) begin
                  w_state_nxt = S_HDR_C;
               end
            end
         end
         S_HDR_C: begin
            if (w_accept) begin
               if (s_data == 32'd0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_RUN;
                  w_run_ld    = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (r_run_cnt == 32'd1) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath and registered outputs ----------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_rb          <= RB_NONE;
         r_cnt         <= 32'd0;
         r_idx         <= 32'd0;
         r_run_cnt     <= 32'd0;
         r_err_code    <= 2'd0;
         r_addr_ext    <= 32'd0;
         r_wdata_ext   <= 32'd0;
         r_addr_ext_2  <= 32'd0;
         r_wdata_ext_2 <= 32'd0;
         r_wen_ext     <= 1'b0;
         r_ren_ext     <= 1'b0;
         r_wen_ext_2   <= 1'b0;
         r_ren_ext_2   <= 1'b0;
         r_cpu_enable  <= 1'b0;
      end else begin
         // Enables are single-cycle strobes.
         r_wen_ext   <= 1'b0;
         r_ren_ext   <= 1'b0;
         r_wen_ext_2 <= 1'b0;
         r_ren_ext_2 <= 1'b0;

         if (w_clear) begin
            r_cnt      <= 32'd0;
            r_idx      <= 32'd0;
            r_run_cnt  <= 32'd0;
            r_err_code <= 2'd0;
         end
         if (w_hdr_ld) begin
            r_cnt <= s_data;
            r_idx <= 32'd0;
         end
         if (w_wr_i) begin
            r_wen_ext   <= 1'b1;
            r_addr_ext  <= r_idx * STEP;
            r_wdata_ext <= s_data;
            r_idx       <= r_idx + 32'd1;
         end
         if (w_wr_d) begin
            r_wen_ext_2   <= 1'b1;
            r_addr_ext_2  <= r_idx * STEP;
            r_wdata_ext_2 <= s_data;
            r_idx         <= r_idx + 32'd1;
         end
         if (w_err_set) r_err_code <= w_err_val;

         // Address and write data are held, so the readback reuses them unchanged.
         if (RB_EN) begin
            case (r_rb)
               RB_NONE: if (w_wr_i || w_wr_d) r_rb <= RB_WR;
               RB_WR: begin
                  r_rb        <= RB_RD;
                  r_ren_ext   <= (r_state == S_LOAD_I);
                  r_ren_ext_2 <= (r_state == S_LOAD_D);
               end
               default: r_rb <= RB_NONE;
            endcase
         end

         if (w_run_ld) begin
            r_cpu_enable <= 1'b1;
            r_run_cnt    <= s_data;
         end else if (r_state == S_RUN) begin
            r_run_cnt <= r_run_cnt - 32'd1;
            if (r_run_cnt == 32'd1) r_cpu_enable <= 1'b0;
         end
      end
   end

   assign addr_ext    = r_addr_ext;
   assign wdata_ext   = r_wdata_ext;
   assign wen_ext     = r_wen_ext;
   assign ren_ext     = r_ren_ext;
   assign addr_ext_2  = r_addr_ext_2;
   assign wdata_ext_2 = r_wdata_ext_2;
   assign wen_ext_2   = r_wen_ext_2;
   assign ren_ext_2   = r_ren_ext_2;
   assign cpu_enable  = r_cpu_enable;
   assign busy        = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
   assign done        = (r_state == S_DONE);
   assign error       = (r_state == S_ERR);
   assign err_code    = r_err_code;

endmodule
